// File: rtl/ddr_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr_wr_pkg
// Brief    : Shared types and constants for the DDR write-burst controller.
// Revision : 1.0
// ============================================================================
package ddr_wr_pkg;

  localparam int DDR_DATA_WIDTH = 256;
  localparam int DDR_BURST_LEN  = 16;

  function automatic int beat_bytes(input int width);
    return width / 8;
  endfunction

  localparam int BYTES_PER_BEAT = beat_bytes(DDR_DATA_WIDTH);
  localparam int BURST_BYTES    = DDR_BURST_LEN * BYTES_PER_BEAT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/wr_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : wr_skid_buf
// Brief    : 2-entry buffer between a 1-cycle-latency FIFO read port and AXI W.
// Revision : 1.0
// ============================================================================
module wr_skid_buf #(
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_issue,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  pop,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  room
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  in_flight;
  logic [1:0]            count;
  logic [1:0]            committed;

  // Space is judged after this cycle's pop so a steady one-beat-per-cycle stream is sustained.
  assign committed = count + {1'b0, in_flight} - {1'b0, pop};
  assign room      = (committed < 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      in_flight <= 1'b0;
      count     <= 2'd0;
    end else begin
      in_flight <= rd_issue;
      if (in_flight) begin
        mem[wr_ptr] <= rd_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, in_flight} - {1'b0, pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/ddr_wr_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ddr_wr_burst_ctrl
// Brief    : Drains the video FIFO into DDR as fixed-length AXI4 write bursts.
// Revision : 1.0
// ============================================================================
module ddr_wr_burst_ctrl
  import ddr_wr_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 28,
  parameter int                    DATA_WIDTH   = 256,
  parameter int                    LEVEL_WIDTH  = 11,
  parameter int                    BURST_LEN    = 16,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BASE   = '0,
  parameter int                    FRAME_BURSTS = 3072
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  output logic                    fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
  input  logic                    fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0]  fifo_rd_water_level,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int                     CNT_W     = $clog2(BURST_LEN + 1);
  localparam int                     BCNT_W    = $clog2(FRAME_BURSTS + 1);
  localparam logic [CNT_W-1:0]       LEN_C     = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]       LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [BCNT_W-1:0]      LAST_BRST = BCNT_W'(FRAME_BURSTS - 1);
  localparam logic [LEVEL_WIDTH-1:0] LVL_THR   = LEVEL_WIDTH'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_INC  = ADDR_WIDTH'(BURST_LEN * beat_bytes(DATA_WIDTH));

  wr_state_e             state;
  wr_state_e             state_nx;
  logic [ADDR_WIDTH-1:0] burst_addr;
  logic [BCNT_W-1:0]     burst_cnt;
  logic [CNT_W-1:0]      rd_cnt;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  fs_pending;
  logic                  level_ok;
  logic                  w_hs;
  logic                  skid_room;

  assign level_ok = (fifo_rd_water_level >= LVL_THR);
  assign w_hs     = m_wvalid & m_wready;
  assign m_awaddr = burst_addr;
  assign m_awlen  = 8'(BURST_LEN - 1);
  assign m_wstrb  = '1;
  assign m_wlast  = m_wvalid && (beat_cnt == LAST_BEAT);

  assign fifo_rd_en = (state == ST_W) && !fifo_rd_empty && skid_room && (rd_cnt < LEN_C);

  wr_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_issue  (fifo_rd_en),
    .rd_data   (fifo_rd_data),
    .pop       (w_hs),
    .out_valid (m_wvalid),
    .out_data  (m_wdata),
    .room      (skid_room)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    m_awvalid = 1'b0;
    m_bready  = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (level_ok) state_nx = ST_AW;
      end
      ST_AW: begin
        m_awvalid = 1'b1;
        if (m_awready) state_nx = ST_W;
      end
      ST_W: begin
        if (w_hs && m_wlast) state_nx = ST_B;
      end
      ST_B: begin
        m_bready = 1'b1;
        if (m_bvalid) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt   <= '0;
      beat_cnt <= '0;
    end else if (state != ST_W) begin
      rd_cnt   <= '0;
      beat_cnt <= '0;
    end else begin
      if (fifo_rd_en) rd_cnt <= rd_cnt + 1'b1;
      if (w_hs) beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // A frame restart only takes effect when the next burst is launched, never mid-burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_addr <= FRAME_BASE;
      burst_cnt  <= '0;
      fs_pending <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start) fs_pending <= 1'b1;
      if ((state == ST_IDLE) && level_ok && (fs_pending || frame_start)) begin
        burst_addr <= FRAME_BASE;
        burst_cnt  <= '0;
        fs_pending <= 1'b0;
      end
      if ((state == ST_B) && m_bvalid) begin
        if (burst_cnt == LAST_BRST) begin
          frame_done <= 1'b1;
          burst_addr <= FRAME_BASE;
          burst_cnt  <= '0;
        end else begin
          burst_addr <= burst_addr + ADDR_INC;
          burst_cnt  <= burst_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr_wr_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_wr_burst_ctrl
// Brief    : Directed self-checking bench for ddr_wr_burst_ctrl (3-burst frames).
// Revision : 1.0
// ============================================================================
module tb_ddr_wr_burst_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         frame_start = 1'b0;
  logic         fifo_rd_en;
  logic [255:0] fifo_rd_data;
  logic         fifo_rd_empty;
  logic [10:0]  fifo_rd_water_level;
  logic [27:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic         m_awvalid;
  logic         m_awready = 1'b0;
  logic [255:0] m_wdata;
  logic [31:0]  m_wstrb;
  logic         m_wlast;
  logic         m_wvalid;
  logic         m_wready = 1'b0;
  logic         m_bvalid = 1'b0;
  logic         m_bready;
  logic         busy;
  logic         frame_done;

  int wr_idx  = 0;
  int rd_idx  = 0;
  int exp_idx = 0;
  int checks  = 0;
  int errors  = 0;
  int fd_cnt  = 0;

  ddr_wr_burst_ctrl #(
    .ADDR_WIDTH   (28),
    .DATA_WIDTH   (256),
    .LEVEL_WIDTH  (11),
    .BURST_LEN    (16),
    .FRAME_BASE   (28'h0),
    .FRAME_BURSTS (3)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .frame_start         (frame_start),
    .fifo_rd_en          (fifo_rd_en),
    .fifo_rd_data        (fifo_rd_data),
    .fifo_rd_empty       (fifo_rd_empty),
    .fifo_rd_water_level (fifo_rd_water_level),
    .m_awaddr            (m_awaddr),
    .m_awlen             (m_awlen),
    .m_awvalid           (m_awvalid),
    .m_awready           (m_awready),
    .m_wdata             (m_wdata),
    .m_wstrb             (m_wstrb),
    .m_wlast             (m_wlast),
    .m_wvalid            (m_wvalid),
    .m_wready            (m_wready),
    .m_bvalid            (m_bvalid),
    .m_bready            (m_bready),
    .busy                (busy),
    .frame_done          (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] word(input int i);
    return {8{32'hA500_0000 + 32'(i)}};
  endfunction

  // FIFO model: word i is the i-th word pushed; read data appears the cycle after fifo_rd_en.
  assign fifo_rd_empty       = (wr_idx == rd_idx);
  assign fifo_rd_water_level = 11'(wr_idx - rd_idx);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= word(rd_idx);
      rd_idx       <= rd_idx + 1;
    end
  end

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_burst(input logic [27:0] exp_addr, input int aw_stall, input bit rand_w,
                          input bit fs_mid, input int rst_at, input bit exp_fd);
    int cyc;
    int beats;
    int rd_base;
    int waited;
    bit fs_sent;
    beats   = 0;
    fs_sent = 1'b0;
    waited  = 0;
    while (!m_awvalid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("aw_valid", 256'(m_awvalid), 256'(1));
    chk("aw_addr", 256'(m_awaddr), 256'(exp_addr));
    chk("aw_len", 256'(m_awlen), 256'(15));
    for (int s = 0; s < aw_stall; s++) begin
      @(negedge clk);
      chk("aw_hold_valid", 256'(m_awvalid), 256'(1));
      chk("aw_hold_addr", 256'(m_awaddr), 256'(exp_addr));
    end
    m_awready = 1'b1;
    rd_base   = rd_idx;
    @(negedge clk);
    m_awready = 1'b0;
    chk("rd_en_first", 256'(fifo_rd_en), 256'(1));
    chk("wvalid_early", 256'(m_wvalid), 256'(0));
    cyc = 0;
    while (beats < 16 && cyc < 200) begin
      if (beats == rst_at) begin
        rst_n = 1'b0;
        m_wready = 1'b0;
        #1;
        chk("rst_rd_en", 256'(fifo_rd_en), 256'(0));
        chk("rst_awvalid", 256'(m_awvalid), 256'(0));
        chk("rst_wvalid", 256'(m_wvalid), 256'(0));
        chk("rst_wlast", 256'(m_wlast), 256'(0));
        chk("rst_bready", 256'(m_bready), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_frame_done", 256'(frame_done), 256'(0));
        chk("rst_awaddr", 256'(m_awaddr), 256'(0));
        chk("rst_wdata", m_wdata, 256'(0));
        return;
      end
      m_wready = rand_w ? 1'($urandom_range(0, 1)) : 1'b1;
      if (fs_mid && beats == 8 && !fs_sent) begin
        frame_start = 1'b1;
        fs_sent     = 1'b1;
      end
      #1;
      chk("prefetch_le2", 256'((rd_idx - exp_idx) <= 2), 256'(1));
      chk("reads_le16", 256'((rd_idx - rd_base) <= 16), 256'(1));
      if (m_wvalid && m_wready) begin
        chk("wdata", m_wdata, word(exp_idx));
        chk("wlast", 256'(m_wlast), 256'(beats == 15));
        chk("wstrb", 256'(m_wstrb), 256'(32'hFFFF_FFFF));
        if (!rand_w) chk("beat_cycle", 256'(cyc), 256'(beats + 2));
        exp_idx++;
        beats++;
      end
      @(negedge clk);
      frame_start = 1'b0;
      cyc++;
    end
    m_wready = 1'b0;
    chk("beats_done", 256'(beats), 256'(16));
    chk("reads_total", 256'(rd_idx - rd_base), 256'(16));
    chk("bready", 256'(m_bready), 256'(1));
    chk("wvalid_in_b", 256'(m_wvalid), 256'(0));
    m_bvalid = 1'b1;
    @(negedge clk);
    m_bvalid = 1'b0;
    chk("busy_idle", 256'(busy), 256'(0));
    chk("frame_done", 256'(frame_done), 256'(exp_fd));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_rd_en", 256'(fifo_rd_en), 256'(0));
    chk("reset_awvalid", 256'(m_awvalid), 256'(0));
    chk("reset_wvalid", 256'(m_wvalid), 256'(0));
    chk("reset_wlast", 256'(m_wlast), 256'(0));
    chk("reset_bready", 256'(m_bready), 256'(0));
    chk("reset_busy", 256'(busy), 256'(0));
    chk("reset_frame_done", 256'(frame_done), 256'(0));
    chk("reset_awaddr", 256'(m_awaddr), 256'(0));
    chk("reset_wdata", m_wdata, 256'(0));
    rst_n  = 1'b1;
    wr_idx = wr_idx + 15;
    repeat (4) begin
      @(negedge clk);
      chk("no_aw_at_15", 256'(m_awvalid), 256'(0));
      chk("idle_at_15", 256'(busy), 256'(0));
    end
    wr_idx = wr_idx + 1;
    @(negedge clk);
    chk("aw_after_16", 256'(m_awvalid), 256'(1));
    do_burst(28'h000, 0, 1'b0, 1'b0, -1, 1'b0);

    wr_idx = wr_idx + 16;
    do_burst(28'h200, 5, 1'b1, 1'b0, -1, 1'b0);
    wr_idx = wr_idx + 16;
    do_burst(28'h400, 0, 1'b0, 1'b0, -1, 1'b1);
    @(negedge clk);
    chk("frame_done_single", 256'(frame_done), 256'(0));

    wr_idx = wr_idx + 16;
    do_burst(28'h000, 0, 1'b0, 1'b0, -1, 1'b0);
    wr_idx = wr_idx + 16;
    do_burst(28'h200, 0, 1'b0, 1'b1, -1, 1'b0);
    wr_idx = wr_idx + 16;
    do_burst(28'h000, 0, 1'b0, 1'b0, -1, 1'b0);
    @(negedge clk);
    chk("frame_done_count", 256'(fd_cnt), 256'(1));

    wr_idx = wr_idx + 16;
    do_burst(28'h200, 0, 1'b0, 1'b0, 7, 1'b0);
    repeat (2) @(negedge clk);
    exp_idx = rd_idx;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 256'(busy), 256'(0));
    chk("post_rst_awaddr", 256'(m_awaddr), 256'(0));
    wr_idx = wr_idx + 16;
    do_burst(28'h000, 0, 1'b0, 1'b0, -1, 1'b0);
    @(negedge clk);
    chk("frame_done_final", 256'(fd_cnt), 256'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ddr_wr_burst_ctrl.md
# ddr_wr_burst_ctrl

Drains the 256-bit read side of the 16-in/256-out video write FIFO and writes the pixel stream into DDR as fixed-length AXI4 write bursts. It runs entirely in the FIFO read clock domain, which is the DDR controller user clock, and sits between the FIFO read port and the DDR controller AXI slave write channels. Bursts are issued to a linear frame buffer that wraps back to its base address at each frame boundary.

## Interface
- ADDR_WIDTH, 28, AXI byte address width
- DATA_WIDTH, 256, FIFO read and AXI W data width; 32 bytes per beat
- LEVEL_WIDTH, 11, width of the FIFO read water level
- BURST_LEN, 16, beats per burst, 1..256; awlen = BURST_LEN-1
- FRAME_BASE, 0, frame buffer byte base address; aligned to BURST_LEN*32
- FRAME_BURSTS, 3072, bursts per frame (1024x768x16 bit / 256 / 16)

Ports:
- clk  in  1  FIFO read / DDR user clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  single-cycle pulse; next burst restarts at FRAME_BASE
- fifo_rd_en  out  1  FIFO read enable
- fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
- fifo_rd_empty  in  1  FIFO empty
- fifo_rd_water_level  in  LEVEL_WIDTH  FIFO read-side occupancy in 256-bit words
- m_awaddr  out  ADDR_WIDTH  burst byte address
- m_awlen  out  8  constant BURST_LEN-1 (INCR, 32-byte size implied)
- m_awvalid / m_awready  out / in  1  AW handshake
- m_wdata  out  DATA_WIDTH  write data
- m_wstrb  out  DATA_WIDTH/8  all ones
- m_wlast  out  1  final beat of a burst
- m_wvalid / m_wready  out / in  1  W handshake
- m_bvalid  in  1  write response valid
- m_bready  out  1  write response ready
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  single-cycle pulse after the last burst of a frame completes

## Operation
- FSM states: IDLE, AW, W, B.
- IDLE to AW: when fifo_rd_water_level >= BURST_LEN. Any pending frame_start is applied first, setting the burst address to FRAME_BASE and the burst count to 0.
- AW: m_awvalid=1 and m_awaddr held stable until m_awready; then go to W.
- W: stream exactly BURST_LEN beats; m_wlast on beat BURST_LEN-1. After the last handshake, go to B.
- B: m_bready=1. On m_bvalid, go to IDLE, add BURST_LEN*32 to the address and increment the burst count.
  - If the count reaches FRAME_BURSTS: pulse frame_done, reset the address to FRAME_BASE and the count to 0.
- The bresp value is ignored.
- Read datapath uses a 2-entry skid buffer.
  - fifo_rd_en = in W, and !fifo_rd_empty, and (buffered + in-flight) < 2, and reads issued < BURST_LEN.
  - Returned data is written into the skid buffer.
  - m_wvalid = skid buffer non-empty; m_wdata = head entry.
  - Exactly BURST_LEN reads are issued per burst; there are no reads outside W.
- frame_start arriving in AW, W or B is latched and applied at the next IDLE-to-AW decision. The burst in progress always completes at its old address. A second pulse before application has no additional effect.
- Address arithmetic is modulo 2^ADDR_WIDTH.

## Timing
- Reset values:
  - fifo_rd_en, m_awvalid, m_wvalid, m_wlast, m_bready, busy, frame_done = 0.
  - m_awaddr = FRAME_BASE.
  - m_wdata = 0.
  - Skid buffer empty, counters 0, frame_start latch clear.
- Reset asserted mid-burst abandons the burst immediately. The DDR side is reset together with this block.
- IDLE to m_awvalid: 1 cycle after the water-level condition is true.
- First fifo_rd_en: the cycle W is entered. First m_wvalid: 2 cycles after entering W.
- With m_wready held high: one beat per cycle, BURST_LEN consecutive beats.
- With m_wready low: m_wvalid, m_wdata and m_wlast are held. No more than 2 words are fetched beyond the last accepted beat, and none beyond BURST_LEN.
- frame_done is asserted in the cycle following the final B handshake of a frame.
- The AXI valid signals never depend combinationally on the corresponding ready.

## Structure
- Shared package (ddr_wr_pkg) holds:
  - FSM state enum.
  - BYTES_PER_BEAT = DATA_WIDTH/8.
  - BURST_BYTES = BURST_LEN*BYTES_PER_BEAT.
- One sub-module, wr_skid_buf: 2-entry, 1-cycle-latency-aware FIFO-to-AXI-W buffer with occupancy and in-flight tracking.

## Test plan
- Water level 15 then 16, m_awready=1, m_wready=1: no AW at 15. At 16, AW with addr 0x0 and awlen 15, then 16 back-to-back beats, m_wlast on beat 15, exactly 16 fifo_rd_en.
- m_wready randomly toggled at 50% over one burst: data order matches FIFO order, no beat lost or duplicated, never more than 2 words prefetched.
- Two consecutive bursts: second m_awaddr = 0x200; m_awvalid held across a 5-cycle m_awready stall with the address stable.
- FRAME_BURSTS=3 run to completion: frame_done pulses once after the third B handshake; the next burst address is FRAME_BASE.
- frame_start pulsed mid-W of burst 2: burst 2 completes at 0x200, burst 3 goes to 0x0, and no frame_done pulse is generated.
- rst_n asserted during W beat 7: all outputs reach reset values asynchronously; after release the FSM is IDLE with address FRAME_BASE.
